cache_replace_ctrl: RTL and testbench



---
 rtl/cache_replace_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_cache_replace_ctrl.sv | 504 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_replace_ctrl.sv
// Cache miss replacement controller for a 4-way tag store.
//
// Takes one miss at a time from the read/write pipeline. It picks a free way if one
// exists, otherwise the round-robin victim. A valid+dirty victim is written back first.
// Then the line is refilled and the new tag is written as valid and clean.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   miss_*              miss request from the pipeline (valid/ready, index, tag)
//   done, done_way      one-cycle completion pulse and the way that was installed
//   sel                 tag-store ownership select (1 while a miss is being handled)
//   ri_read*            tag-store lookup: index, way select, tag word, free-way info
//   ri_write*           tag-store tag write strobe, index, way and data
//   wb_*                writeback request/ack and victim line identity
//   rf_*                refill request/ack and new line identity
module cache_replace_ctrl #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned TAG_ADDR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      miss_valid,
    input  logic [ADDR_WIDTH-1:0]     miss_index,
    input  logic [TAG_ADDR_WIDTH-1:0] miss_tag,
    output logic                      miss_ready,
    output logic                      done,
    output logic [1:0]                done_way,
    output logic                      sel,
    output logic [ADDR_WIDTH-1:0]     ri_readAddress,
    output logic [1:0]                ri_readChannel,
    input  logic [31:0]               ri_readData,
    input  logic                      ri_isHaveFreeBlock,
    input  logic [1:0]                ri_freeBlockNum,
    output logic [ADDR_WIDTH-1:0]     ri_writeAddress,
    output logic [1:0]                ri_writeChannel,
    output logic                      ri_writeEnable,
    output logic [31:0]               ri_writeData,
    output logic                      wb_req,
    input  logic                      wb_ack,
    output logic [ADDR_WIDTH-1:0]     wb_index,
    output logic [TAG_ADDR_WIDTH-1:0] wb_tag,
    output logic [1:0]                wb_way,
    output logic                      rf_req,
    input  logic                      rf_ack,
    output logic [ADDR_WIDTH-1:0]     rf_index,
    output logic [TAG_ADDR_WIDTH-1:0] rf_tag,
    output logic [1:0]                rf_way
);

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StChoose,
        StCheck,
        StWb,
        StRefill,
        StTagWr,
        StDone
    } state_e;

    state_e                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     index_q, index_d;
    logic [TAG_ADDR_WIDTH-1:0] tag_q, tag_d;
    logic [TAG_ADDR_WIDTH-1:0] wb_tag_q, wb_tag_d;
    logic [1:0]                way_q, way_d;
    logic [1:0]                rr_q, rr_d;

    // Only the valid/dirty bits and the tag field of the read word are meaningful.
    logic unused_read_bits;
    assign unused_read_bits = ^ri_readData;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            index_q  <= '0;
            tag_q    <= '0;
            wb_tag_q <= '0;
            way_q    <= '0;
            rr_q     <= '0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            tag_q    <= tag_d;
            wb_tag_q <= wb_tag_d;
            way_q    <= way_d;
            rr_q     <= rr_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        index_d         = index_q;
        tag_d           = tag_q;
        wb_tag_d        = wb_tag_q;
        way_d           = way_q;
        rr_d            = rr_q;
        miss_ready      = 1'b0;
        done            = 1'b0;
        done_way        = '0;
        sel             = 1'b0;
        ri_readAddress  = '0;
        ri_readChannel  = '0;
        ri_writeAddress = '0;
        ri_writeChannel = '0;
        ri_writeEnable  = 1'b0;
        ri_writeData    = '0;
        wb_req          = 1'b0;
        wb_index        = '0;
        wb_tag          = '0;
        wb_way          = '0;
        rf_req          = 1'b0;
        rf_index        = '0;
        rf_tag          = '0;
        rf_way          = '0;

        // The tag store belongs to this block from LOOKUP through TAGWR. The read index
        // stays on the miss set for that whole span.
        if (state_q != StIdle && state_q != StDone) begin
            sel            = 1'b1;
            ri_readAddress = index_q;
        end

        unique case (state_q)
            StIdle: begin
                miss_ready = 1'b1;
                if (miss_valid) begin
                    index_d = miss_index;
                    tag_d   = miss_tag;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                state_d = StChoose;
            end
            StChoose: begin
                // A free way costs nothing to replace, so the round-robin pointer only
                // advances when a valid line has to be evicted.
                if (ri_isHaveFreeBlock) begin
                    way_d = ri_freeBlockNum;
                end else begin
                    way_d = rr_q;
                    rr_d  = rr_q + 2'd1;
                end
                state_d = StCheck;
            end
            StCheck: begin
                ri_readChannel = way_q;
                if (ri_readData[TAG_ADDR_WIDTH] && ri_readData[TAG_ADDR_WIDTH+1]) begin
                    wb_tag_d = ri_readData[TAG_ADDR_WIDTH-1:0];
                    state_d  = StWb;
                end else begin
                    state_d = StRefill;
                end
            end
            StWb: begin
                wb_req   = 1'b1;
                wb_index = index_q;
                wb_tag   = wb_tag_q;
                wb_way   = way_q;
                if (wb_ack) begin
                    state_d = StRefill;
                end
            end
            StRefill: begin
                rf_req   = 1'b1;
                rf_index = index_q;
                rf_tag   = tag_q;
                rf_way   = way_q;
                if (rf_ack) begin
                    state_d = StTagWr;
                end
            end
            StTagWr: begin
                ri_writeEnable                      = 1'b1;
                ri_writeAddress                     = index_q;
                ri_writeChannel                     = way_q;
                ri_writeData[TAG_ADDR_WIDTH-1:0]    = tag_q;
                ri_writeData[TAG_ADDR_WIDTH]        = 1'b1;
                state_d                             = StDone;
            end
            StDone: begin
                done     = 1'b1;
                done_way = way_q;
                state_d  = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_replace_ctrl.sv
// Self-checking bench for cache_replace_ctrl: tag-store stub, ack responders,
// scoreboard queues filled by a high-level replacement model, and a negedge monitor.
module tb_cache_replace_ctrl;

    localparam int AW = 8;
    localparam int TW = 8;
    localparam logic [31:0] VALID = 32'h100;
    localparam logic [31:0] DIRTY = 32'h200;

    logic          clk = 1'b0;
    logic          rst;
    logic          miss_valid;
    logic [AW-1:0] miss_index;
    logic [TW-1:0] miss_tag;
    logic          miss_ready;
    logic          done;
    logic [1:0]    done_way;
    logic          sel;
    logic [AW-1:0] ri_readAddress;
    logic [1:0]    ri_readChannel;
    logic [31:0]   ri_readData;
    logic          ri_isHaveFreeBlock;
    logic [1:0]    ri_freeBlockNum;
    logic [AW-1:0] ri_writeAddress;
    logic [1:0]    ri_writeChannel;
    logic          ri_writeEnable;
    logic [31:0]   ri_writeData;
    logic          wb_req, wb_ack;
    logic [AW-1:0] wb_index;
    logic [TW-1:0] wb_tag;
    logic [1:0]    wb_way;
    logic          rf_req, rf_ack;
    logic [AW-1:0] rf_index;
    logic [TW-1:0] rf_tag;
    logic [1:0]    rf_way;

    logic wb_ack_drv, rf_ack_drv, spur_wb, spur_rf;
    assign wb_ack = wb_ack_drv | spur_wb;
    assign rf_ack = rf_ack_drv | spur_rf;

    cache_replace_ctrl #(
        .ADDR_WIDTH    (AW),
        .TAG_ADDR_WIDTH(TW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_valid        (miss_valid),
        .miss_index        (miss_index),
        .miss_tag          (miss_tag),
        .miss_ready        (miss_ready),
        .done              (done),
        .done_way          (done_way),
        .sel               (sel),
        .ri_readAddress    (ri_readAddress),
        .ri_readChannel    (ri_readChannel),
        .ri_readData       (ri_readData),
        .ri_isHaveFreeBlock(ri_isHaveFreeBlock),
        .ri_freeBlockNum   (ri_freeBlockNum),
        .ri_writeAddress   (ri_writeAddress),
        .ri_writeChannel   (ri_writeChannel),
        .ri_writeEnable    (ri_writeEnable),
        .ri_writeData      (ri_writeData),
        .wb_req            (wb_req),
        .wb_ack            (wb_ack),
        .wb_index          (wb_index),
        .wb_tag            (wb_tag),
        .wb_way            (wb_way),
        .rf_req            (rf_req),
        .rf_ack            (rf_ack),
        .rf_index          (rf_index),
        .rf_tag            (rf_tag),
        .rf_way            (rf_way)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- tag-store stub: registered address, combinational way read -------------
    logic [31:0]   store [256][4];
    logic [AW-1:0] raddr_q = '0;
    logic          clr_store, pl_en;
    logic [AW-1:0] pl_idx;
    logic [1:0]    pl_way;
    logic [31:0]   pl_data;

    always @(posedge clk) begin
        raddr_q <= ri_readAddress;
        if (clr_store) begin
            for (int s = 0; s < 256; s++) for (int w = 0; w < 4; w++) store[s][w] <= '0;
        end else if (pl_en) begin
            store[pl_idx][pl_way] <= pl_data;
        end else if (ri_writeEnable) begin
            store[ri_writeAddress][ri_writeChannel] <= ri_writeData;
        end
    end

    assign ri_readData = store[raddr_q][ri_readChannel];

    always_comb begin
        ri_isHaveFreeBlock = 1'b0;
        ri_freeBlockNum    = 2'd0;
        for (int w = 3; w >= 0; w--) begin
            if (!store[raddr_q][w][8]) begin
                ri_isHaveFreeBlock = 1'b1;
                ri_freeBlockNum    = w[1:0];
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [7:0] idx;
        logic [7:0] tag;
        logic [1:0] way;
        int         hold;
    } line_t;
    typedef struct {
        logic [7:0]  idx;
        logic [1:0]  way;
        logic [31:0] data;
    } wr_t;
    typedef struct {
        logic [1:0] way;
        int         acc;
        int         lat;
    } done_t;

    line_t exp_wb[$];
    line_t exp_rf[$];
    wr_t   exp_wr[$];
    done_t exp_done[$];
    int    wb_dq[$];
    int    rf_dq[$];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_chk++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Reference model: the set contents and the round-robin pointer as plain arrays.
    logic [31:0] ref_mem [256][4];
    int          rr_m;

    // ---------------- ack responders: ack after a per-request delay ----------------
    int wb_cnt, rf_cnt, wb_dly, rf_dly;
    initial begin
        wb_ack_drv = 1'b0;
        rf_ack_drv = 1'b0;
        wb_cnt = 0;
        rf_cnt = 0;
        wb_dly = 0;
        rf_dly = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                wb_ack_drv = 1'b0;
                rf_ack_drv = 1'b0;
                wb_cnt = 0;
                rf_cnt = 0;
            end else begin
                if (wb_req) begin
                    if (wb_cnt == 0) wb_dly = (wb_dq.size() > 0) ? wb_dq.pop_front() : 0;
                    wb_ack_drv = (wb_cnt == wb_dly);
                    wb_cnt++;
                end else begin
                    wb_ack_drv = 1'b0;
                    wb_cnt = 0;
                end
                if (rf_req) begin
                    if (rf_cnt == 0) rf_dly = (rf_dq.size() > 0) ? rf_dq.pop_front() : 0;
                    rf_ack_drv = (rf_cnt == rf_dly);
                    rf_cnt++;
                end else begin
                    rf_ack_drv = 1'b0;
                    rf_cnt = 0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    bit          busy, wb_prev, rf_prev, have_wb, have_rf;
    int          wb_len, rf_len, wb_count, done_count, last_rf_hold;
    line_t       cur_wb, cur_rf;
    logic [1:0]  last_done_way;
    logic [TW-1:0] last_wb_tag;
    logic [31:0] last_wr_data;

    initial begin
        busy = 0; wb_prev = 0; rf_prev = 0; have_wb = 0; have_rf = 0;
        wb_len = 0; rf_len = 0; wb_count = 0; done_count = 0; last_rf_hold = 0;
        last_done_way = '0; last_wb_tag = '0; last_wr_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy = 0; wb_prev = 0; rf_prev = 0; have_wb = 0; have_rf = 0;
            end else begin
                chk("miss_ready", 32'(miss_ready), 32'(!busy));
                chk("sel", 32'(sel), 32'(busy && !done));

                if (wb_req) begin
                    if (!wb_prev) begin
                        wb_len = 0;
                        wb_count++;
                        if (exp_wb.size() == 0) begin
                            have_wb = 0;
                            fail_now("wb_req", "request seen while no writeback expected");
                        end else begin
                            cur_wb  = exp_wb.pop_front();
                            have_wb = 1;
                        end
                    end
                    wb_len++;
                    last_wb_tag = wb_tag;
                    if (have_wb) begin
                        chk("wb_index", 32'(wb_index), 32'(cur_wb.idx));
                        chk("wb_tag", 32'(wb_tag), 32'(cur_wb.tag));
                        chk("wb_way", 32'(wb_way), 32'(cur_wb.way));
                    end
                end else if (wb_prev && have_wb) begin
                    chk("wb_req_cycles", 32'(wb_len), 32'(cur_wb.hold));
                    have_wb = 0;
                end
                wb_prev = wb_req;

                if (rf_req) begin
                    if (!rf_prev) begin
                        rf_len = 0;
                        if (exp_rf.size() == 0) begin
                            have_rf = 0;
                            fail_now("rf_req", "request seen while no refill expected");
                        end else begin
                            cur_rf  = exp_rf.pop_front();
                            have_rf = 1;
                        end
                    end
                    rf_len++;
                    if (have_rf) begin
                        chk("rf_index", 32'(rf_index), 32'(cur_rf.idx));
                        chk("rf_tag", 32'(rf_tag), 32'(cur_rf.tag));
                        chk("rf_way", 32'(rf_way), 32'(cur_rf.way));
                    end
                end else if (rf_prev && have_rf) begin
                    chk("rf_req_cycles", 32'(rf_len), 32'(cur_rf.hold));
                    last_rf_hold = rf_len;
                    have_rf = 0;
                end
                rf_prev = rf_req;

                if (ri_writeEnable) begin
                    last_wr_data = ri_writeData;
                    if (exp_wr.size() == 0) begin
                        fail_now("tag_write", "write strobe seen while no tag write expected");
                    end else begin
                        wr_t w;
                        w = exp_wr.pop_front();
                        chk("wr_addr", 32'(ri_writeAddress), 32'(w.idx));
                        chk("wr_way", 32'(ri_writeChannel), 32'(w.way));
                        chk("wr_data", ri_writeData, w.data);
                    end
                end

                if (done) begin
                    done_count++;
                    last_done_way = done_way;
                    if (exp_done.size() == 0) begin
                        fail_now("done", "done pulse seen while no miss outstanding");
                    end else begin
                        done_t d;
                        d = exp_done.pop_front();
                        chk("done_way", 32'(done_way), 32'(d.way));
                        chk("latency", 32'(cyc - d.acc), 32'(d.lat));
                    end
                    busy = 0;
                end
                if (miss_valid && miss_ready) busy = 1;
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge + 1) ----------------
    task automatic clear_all();
        clr_store = 1'b1;
        @(posedge clk);
        #1;
        clr_store = 1'b0;
        for (int s = 0; s < 256; s++) for (int w = 0; w < 4; w++) ref_mem[s][w] = '0;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [1:0] way, input logic [31:0] data);
        pl_en   = 1'b1;
        pl_idx  = idx;
        pl_way  = way;
        pl_data = data;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
        ref_mem[idx][way] = data;
    endtask

    task automatic issue(input logic [7:0] idx, input logic [7:0] tg, input int wd, input int rd,
                         input bit drop);
        int          n;
        int          way;
        logic [31:0] vic;
        bit          wb;
        line_t       l;
        wr_t         w;
        done_t       d;
        miss_valid = 1'b1;
        miss_index = idx;
        miss_tag   = tg;
        n = 0;
        while (!miss_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!miss_ready) begin
            fail_now("miss_accept", "miss_ready stayed 0 for 200 cycles, expected 1");
            miss_valid = 1'b0;
            return;
        end
        // Free way (lowest invalid, as the stub reports it) or round-robin victim.
        way = -1;
        for (int k = 0; k < 4; k++) if (way < 0 && !ref_mem[idx][k][8]) way = k;
        if (way < 0) begin
            way  = rr_m;
            rr_m = (rr_m + 1) % 4;
        end
        vic = ref_mem[idx][way];
        wb  = vic[8] && vic[9];
        if (wb) begin
            l.idx = idx; l.tag = vic[7:0]; l.way = 2'(way); l.hold = wd + 1;
            exp_wb.push_back(l);
            wb_dq.push_back(wd);
        end
        l.idx = idx; l.tag = tg; l.way = 2'(way); l.hold = rd + 1;
        exp_rf.push_back(l);
        rf_dq.push_back(rd);
        w.idx = idx; w.way = 2'(way); w.data = VALID | {24'd0, tg};
        exp_wr.push_back(w);
        d.way = 2'(way); d.acc = cyc; d.lat = 6 + (wb ? wd + 1 : 0) + rd;
        exp_done.push_back(d);
        ref_mem[idx][way] = VALID | {24'd0, tg};
        @(posedge clk);
        #1;
        if (drop) miss_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(exp_done.size() == 0 && miss_ready) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("return_to_idle", 32'(exp_done.size() == 0 && miss_ready), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_miss_ready"}, 32'(miss_ready), 1);
        chk({tag, "_wb_req"}, 32'(wb_req), 0);
        chk({tag, "_sel"}, 32'(sel), 0);
        chk({tag, "_other_outputs"}, 32'(|{done, done_way, ri_readAddress, ri_readChannel,
            ri_writeAddress, ri_writeChannel, ri_writeEnable, ri_writeData, wb_index, wb_tag,
            wb_way, rf_req, rf_index, rf_tag, rf_way}), 0);
    endtask

    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: simulation ran past 40000 cycles, expected to finish sooner");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int exp_v [5];
        int seen_wb;
        rst = 1'b0;
        miss_valid = 1'b0; miss_index = '0; miss_tag = '0;
        spur_wb = 1'b0; spur_rf = 1'b0;
        clr_store = 1'b0; pl_en = 1'b0; pl_idx = '0; pl_way = '0; pl_data = '0;
        rr_m = 0;
        #1 rst = 1'b1;
        clear_all();
        check_reset_outputs("init");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Free way 2 in set 0x10, immediate acks: no writeback, tag 0x1AB into way 2.
        preload(8'h10, 2'd0, VALID | 32'h11);
        preload(8'h10, 2'd1, VALID | 32'h22);
        preload(8'h10, 2'd3, VALID | 32'h33);
        seen_wb = wb_count;
        issue(8'h10, 8'hAB, 0, 0, 1);
        wait_idle();
        chk("t2_no_writeback", 32'(wb_count - seen_wb), 0);
        chk("t2_done_way", 32'(last_done_way), 2);
        chk("t2_tag_word", last_wr_data, 32'h1AB);

        // Full clean set: round-robin victims 0,1,2,3 then wrap to 0.
        exp_v = '{0, 1, 2, 3, 0};
        for (int w = 0; w < 4; w++) preload(8'h05, 2'(w), VALID | 32'(8'h40 + w));
        for (int k = 0; k < 5; k++) begin
            issue(8'h05, 8'(8'h60 + k), 0, 0, 1);
            wait_idle();
            chk("t3_victim", 32'(last_done_way), 32'(exp_v[k]));
        end

        // Reset while the writeback request is pending.
        for (int w = 0; w < 4; w++) preload(8'h30, 2'(w), VALID | 32'(8'h70 + w));
        preload(8'h30, 2'd1, VALID | DIRTY | 32'h77);
        issue(8'h30, 8'h55, 50, 0, 1);
        for (int n = 0; n < 20 && !wb_req; n++) begin
            @(posedge clk);
            #1;
        end
        chk("t_rst_wb_pending", 32'(wb_req), 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_wb");
        @(posedge clk);
        #1;
        exp_wb.delete(); exp_rf.delete(); exp_wr.delete(); exp_done.delete();
        wb_dq.delete(); rf_dq.delete();
        clear_all();
        rr_m = 0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Dirty victim in way 0 (pointer back at 0), refill ack after 5 request cycles.
        preload(8'h20, 2'd0, VALID | DIRTY | 32'hCD);
        for (int w = 1; w < 4; w++) preload(8'h20, 2'(w), VALID | 32'(8'h80 + w));
        seen_wb = wb_count;
        issue(8'h20, 8'hAB, 0, 4, 1);
        wait_idle();
        chk("t4_writeback_seen", 32'(wb_count - seen_wb), 1);
        chk("t4_wb_tag", 32'(last_wb_tag), 32'hCD);
        chk("t4_rf_req_cycles", 32'(last_rf_hold), 5);
        chk("t4_tag_word", last_wr_data, 32'h1AB);
        chk("t4_done_way", 32'(last_done_way), 0);

        // Stray acks while idle, then a second miss held valid across the first one.
        spur_wb = 1'b1;
        spur_rf = 1'b1;
        @(posedge clk);
        #1;
        spur_wb = 1'b0;
        spur_rf = 1'b0;
        seen_wb = done_count;
        issue(8'h40, 8'h12, 1, 1, 0);
        issue(8'h40, 8'h34, 0, 2, 1);
        wait_idle();
        chk("t5_two_done", 32'(done_count - seen_wb), 2);
        chk("t5_second_way", 32'(last_done_way), 1);

        // Randomized misses over a few sets, with occasional line preloads.
        for (int k = 0; k < 60; k++) begin
            logic [31:0] word;
            logic [7:0]  t;
            t = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       word = 32'(t);
                1:       word = VALID | 32'(t);
                2:       word = VALID | DIRTY | 32'(t);
                default: word = DIRTY | 32'(t);
            endcase
            if ($urandom_range(0, 2) == 0) preload(8'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), word);
            issue(8'($urandom_range(0, 3)), 8'($urandom), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), 1);
            wait_idle();
        end

        chk("leftover_expectations",
            32'(exp_wb.size() + exp_rf.size() + exp_wr.size() + exp_done.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
